// File: rtl/udma_hyper_phy_arb.sv
// Round-robin arbiter/sequencer sharing the HyperBus PHY transaction engine
// between NB_CH requesting channels (phy_clk_i domain).
//
// Ports:
//   phy_clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/addr_i/len_i/rw_i    per-channel request level and descriptor
//   gnt_o, done_o              one-hot grant / completion pulses
//   phy_start_o, phy_addr_o,
//   phy_len_o, phy_rw_o        launch pulse and latched descriptor to the PHY
//   phy_done_i                 completion pulse from the PHY
//   phy_abort_o                watchdog abort pulse (timeout build only)
//   running_trans_o, proc_id_o registered busy flag and id for the sys domain
//   err_o                      sticky per-channel timeout flags (timeout build only)
//
// Optional feature: define HYPER_ARB_TIMEOUT_EN to enable the RUN watchdog.
module udma_hyper_phy_arb #(
    parameter int unsigned NB_CH          = 2,
    parameter int unsigned ID_W           = 1,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                phy_clk_i,
    input  logic                rst_ni,
    input  logic [NB_CH-1:0]    req_i,
    input  logic [NB_CH*32-1:0] addr_i,
    input  logic [NB_CH*16-1:0] len_i,
    input  logic [NB_CH-1:0]    rw_i,
    output logic [NB_CH-1:0]    gnt_o,
    output logic [NB_CH-1:0]    done_o,
    output logic                phy_start_o,
    output logic [31:0]         phy_addr_o,
    output logic [15:0]         phy_len_o,
    output logic                phy_rw_o,
    input  logic                phy_done_i,
    output logic                phy_abort_o,
    output logic                running_trans_o,
    output logic [ID_W-1:0]     proc_id_o,
    output logic [NB_CH-1:0]    err_o
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    // Elaboration-time parameter sanity checks
    if (NB_CH < 2 || NB_CH > 8) begin : g_bad_nb_ch
        $error("udma_hyper_phy_arb: NB_CH must be in 2..8");
    end
    if ((1 << ID_W) < NB_CH) begin : g_bad_id_w
        $error("udma_hyper_phy_arb: ID_W too narrow for NB_CH");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("udma_hyper_phy_arb: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {IDLE, ZERO, LAUNCH, RUN, GAP} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      proc_id_q, proc_id_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 rw_q, rw_d;
    logic [NB_CH-1:0]     gnt_q, gnt_d;
    logic [NB_CH-1:0]     done_q, done_d;
    logic                 start_q, start_d;
    logic                 running_q, running_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 finish;

    // Round-robin pick: first requester at or above rr_ptr_q, wrapping
    logic                 found;
    logic [ID_W-1:0]      sel_id, sel_next;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic                 sel_rw;
    int unsigned          idx;

    always_comb begin
        found    = 1'b0;
        sel_id   = '0;
        sel_next = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_rw   = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NB_CH; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NB_CH) idx = idx - NB_CH;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                sel_id   = ID_W'(idx);
                sel_next = (idx == NB_CH - 1) ? '0 : ID_W'(idx + 1);
                sel_addr = addr_i[ADDR_W*idx +: ADDR_W];
                sel_len  = len_i[LEN_W*idx +: LEN_W];
                sel_rw   = rw_i[idx];
            end
        end
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             abort_q, abort_d;
    logic [NB_CH-1:0] err_q, err_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        proc_id_d = proc_id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rw_d      = rw_q;
        gnt_d     = '0;
        done_d    = '0;
        start_d   = 1'b0;
        running_d = 1'b0;
        gap_cnt_d = gap_cnt_q;
        finish    = 1'b0;
`ifdef HYPER_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        abort_d   = 1'b0;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d[sel_id] = 1'b1;
                    proc_id_d     = sel_id;
                    rr_ptr_d      = sel_next;
                    addr_d        = sel_addr;
                    len_d         = sel_len;
                    rw_d          = sel_rw;
                    state_d       = (sel_len == '0) ? ZERO : LAUNCH;
                end
            end
            ZERO: begin
                done_d[proc_id_q] = 1'b1;
                state_d           = IDLE;
            end
            LAUNCH: begin
                start_d   = 1'b1;
                running_d = 1'b1;
`ifdef HYPER_ARB_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
                state_d   = RUN;
            end
            RUN: begin
                running_d = 1'b1;
                // A done arriving in the expiry cycle takes precedence
                if (phy_done_i) finish = 1'b1;
`ifdef HYPER_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    finish            = 1'b1;
                    abort_d           = 1'b1;
                    err_d[proc_id_q]  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
                if (finish) begin
                    running_d         = 1'b0;
                    done_d[proc_id_q] = 1'b1;
                    gap_cnt_d         = GAP_W'(GAP_CYCLES);
                    state_d           = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
                else                         gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            proc_id_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rw_q      <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            proc_id_q <= proc_id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rw_q      <= rw_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            start_q   <= start_d;
            running_q <= running_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    always_ff @(posedge phy_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    assign phy_abort_o = abort_q;
    assign err_o       = err_q;
`else
    assign phy_abort_o = 1'b0;
    assign err_o       = '0;
`endif

    assign gnt_o           = gnt_q;
    assign done_o          = done_q;
    assign phy_start_o     = start_q;
    assign phy_addr_o      = addr_q;
    assign phy_len_o       = len_q;
    assign phy_rw_o        = rw_q;
    assign running_trans_o = running_q;
    assign proc_id_o       = proc_id_q;

endmodule

// File: doc/udma_hyper_phy_arb.md
Name: udma_hyper_phy_arb

Overview:
- Phy-clock-domain arbiter and sequencer that shares the single HyperBus PHY transaction engine between NB_CH requesting channels.
- Selects one requester at a time using round-robin.
- Launches that requester's descriptor into the PHY and tracks completion.
- Drives running_trans_o and proc_id_o, which the sys-domain busy/EOT logic synchronises. Both must therefore be glitch-free registered outputs with a stable id.

Parameters:
- NB_CH, 2, number of requesting channels (2..8).
- ID_W, 1, width of the channel id; must be at least max(1, clog2(NB_CH)).
- GAP_CYCLES, 4, minimum idle cycles (CS recovery) between consecutive PHY transactions; 0 allowed.
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN (used only with the optional feature).

Ports:
- phy_clk_i  in  1  PHY clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NB_CH  per-channel request; level, held until the matching gnt_o.
- addr_i  in  NB_CH*32  per-channel start address; channel k occupies bits [32k+31:32k].
- len_i  in  NB_CH*16  per-channel transfer length in bytes.
- rw_i  in  NB_CH  per-channel direction; 1 = read.
- gnt_o  out  NB_CH  one-hot, one-cycle grant pulse; the descriptor is latched in that cycle.
- done_o  out  NB_CH  one-hot, one-cycle completion pulse.
- phy_start_o  out  1  one-cycle launch pulse to the PHY engine.
- phy_addr_o  out  32  latched address.
- phy_len_o  out  16  latched length.
- phy_rw_o  out  1  latched direction.
- phy_done_i  in  1  one-cycle pulse from the PHY; transaction finished.
- phy_abort_o  out  1  one-cycle abort pulse to the PHY (optional feature only; otherwise tied 0).
- running_trans_o  out  1  high while a PHY transaction is in flight.
- proc_id_o  out  ID_W  id of the last granted channel.
- err_o  out  NB_CH  sticky per-channel timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values:
  - Every output is 0.
  - State is IDLE.
  - The round-robin pointer is 0, so channel 0 has the highest priority on the first arbitration.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states:
  - IDLE
    - If any req_i bit is high, select the first set bit at or above rr_ptr, wrapping modulo NB_CH.
    - Latch addr, len, rw and the id; pulse gnt_o[id]; set proc_id_o = id; set rr_ptr = id+1 mod NB_CH.
    - If the latched len != 0, go to LAUNCH. If len == 0, go to ZERO.
  - ZERO: pulse done_o[id]; go to IDLE. No PHY activity, running_trans_o stays 0, no gap is inserted.
  - LAUNCH: phy_start_o = 1 and running_trans_o = 1 for this cycle; go to RUN.
  - RUN
    - running_trans_o = 1.
    - On phy_done_i: pulse done_o[id], drop running_trans_o in the next cycle, load gap_cnt = GAP_CYCLES.
    - Then go to GAP, or straight to IDLE if GAP_CYCLES == 0.
  - GAP: decrement gap_cnt each cycle; go to IDLE when it reaches 1. req_i is not sampled during GAP.
- Latency:
  - Request sampled in IDLE (cycle t) -> gnt_o at t+1 -> phy_start_o at t+2.
  - phy_done_i at cycle d -> done_o and running_trans_o falling at d+1.
- proc_id_o stays constant from the grant through RUN and GAP, until the next grant. This keeps it stable for at least GAP_CYCLES after running_trans_o falls, for the downstream synchroniser.
- phy_done_i outside RUN is ignored; no pulse is produced.
- Descriptor inputs are sampled only in the grant cycle. Later changes have no effect on the transaction in flight.
- A req_i bit dropped before its grant is simply not selected. No error is raised.
- Simultaneous requests: strictly one grant per arbitration. A channel that is continuously requesting waits at most NB_CH-1 transactions.
- Reset mid-operation: all state and outputs clear asynchronously. An in-flight PHY transaction is not completed and no done_o is pulsed.

Optional Feature:
HYPER_ARB_TIMEOUT_EN
- With the macro defined:
  - A counter runs in RUN and clears on entry to LAUNCH.
  - If it reaches TIMEOUT_CYCLES without phy_done_i: pulse phy_abort_o; set err_o[id] (sticky until reset); pulse done_o[id]; go to GAP as for a normal completion.
  - If phy_done_i arrives in the same cycle the counter expires, phy_done_i wins and no error is raised.
- Without the macro: no counter; phy_abort_o and err_o are tied 0; RUN waits indefinitely.

Test Plan:
1. Reset, then req_i=01, addr0=0x1000, len0=64, rw0=1 -> gnt_o=01 at +1; phy_start_o at +2 with phy_addr_o=0x1000, phy_len_o=64, phy_rw_o=1; proc_id_o=0; running_trans_o high until 1 cycle after phy_done_i; done_o=01.
2. req_i=11 held, GAP_CYCLES=4 -> grants alternate 01,10,01,10; exactly 4 idle cycles between running_trans_o fall and the next gnt_o; proc_id_o alternates 0,1.
3. Channel 1 with len1=0 -> gnt_o=10 then done_o=10 the next cycle; no phy_start_o; running_trans_o stays 0.
4. Spurious phy_done_i in IDLE and in GAP -> no done_o pulses, no state change; change addr_i during RUN -> phy_addr_o unchanged.
5. Assert rst_ni=0 during RUN -> running_trans_o, proc_id_o, gnt_o and done_o all 0 immediately; after release, req_i=10 is granted first only if req_i[0]=0 (rr_ptr=0).
6. With HYPER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, never pulse phy_done_i -> phy_abort_o and done_o=01 at cycle 16 of RUN; err_o=01 stays set; the next request is served normally.
